// File: rtl/nexys_starship_pkg.sv
// Shared types and constants for the starship monster controller:
// game FSM states, slot states, side indices and age width.
package nexys_starship_pkg;

    localparam int unsigned NUM_SIDES = 4;
    localparam int unsigned AGE_W     = 4;

    localparam int unsigned TOP   = 0;
    localparam int unsigned BTM   = 1;
    localparam int unsigned LEFT  = 2;
    localparam int unsigned RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_GAMEOVER = 2'd2
    } game_state_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_ALIVE = 1'b1
    } slot_state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]}
                  + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/nexys_starship_monster_slot.sv
// One monster slot: EMPTY/ALIVE state plus remaining-age counter.
// Ports: clk_i, rst_ni, clear_i, hold_i, tick_i, spawn_grant_i, shoot_i
//        -> alive_o, age_o (registered), timeout_o, killed_o (decisions).
module nexys_starship_monster_slot
    import nexys_starship_pkg::*;
#(
    parameter int unsigned TIMEOUT = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             hold_i,
    input  logic             tick_i,
    input  logic             spawn_grant_i,
    input  logic             shoot_i,
    output logic             alive_o,
    output logic [AGE_W-1:0] age_o,
    output logic             timeout_o,
    output logic             killed_o
);

    slot_state_e      state_q, state_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             is_alive;

    assign is_alive  = (state_q == SLOT_ALIVE);
    assign killed_o  = is_alive & shoot_i;
    // A shot on the last tick saves the player.
    assign timeout_o = is_alive & tick_i & ~shoot_i
                     & (age_q == AGE_W'(1));
    assign alive_o   = is_alive;
    assign age_o     = age_q;

    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        if (clear_i) begin
            state_d = SLOT_EMPTY;
            age_d   = '0;
        end else if (hold_i) begin
            // Game ended this cycle: every slot freezes.
            state_d = state_q;
        end else if (!is_alive) begin
            if (spawn_grant_i) begin
                state_d = SLOT_ALIVE;
                age_d   = AGE_W'(TIMEOUT);
            end
        end else if (shoot_i) begin
            state_d = SLOT_EMPTY;
            age_d   = '0;
        end else if (tick_i) begin
            // age is > 1 here, age 1 raised timeout and hold
            age_d = age_q - AGE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SLOT_EMPTY;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: rtl/nexys_starship_monster_ctrl.sv
// Monster controller: game FSM, spawn arbitration with live cap, score.
// Ports: Clk, Reset(n), start, tick, spawn_req[4], shoot[4]
//        -> monster[4], age[16], score[8], hit, game_over, playing.
module nexys_starship_monster_ctrl
    import nexys_starship_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 5,
    parameter int unsigned MAX_ACTIVE = 3
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    input  logic                     tick,
    input  logic [NUM_SIDES-1:0]     spawn_req,
    input  logic [NUM_SIDES-1:0]     shoot,
    output logic [NUM_SIDES-1:0]     monster,
    output logic [NUM_SIDES*AGE_W-1:0] age,
    output logic [7:0]               score,
    output logic                     hit,
    output logic                     game_over,
    output logic                     playing
);

    localparam logic [2:0] CAP = 3'(MAX_ACTIVE);

    game_state_e          state_q;
    logic [7:0]           score_q, score_d;
    logic                 hit_q, game_over_q, playing_q;

    logic                 in_play, play_tick, clear, any_timeout;
    logic [NUM_SIDES-1:0] play_shoot, alive, timeout, killed, grant;
    logic [2:0]           live, n_kill;
    logic [8:0]           score_sum;

    assign in_play     = (state_q == ST_PLAY);
    assign play_tick   = tick & in_play;
    assign play_shoot  = shoot & {NUM_SIDES{in_play}};
    assign clear       = start & ~in_play;
    assign any_timeout = |timeout;

    for (genvar i = 0; i < NUM_SIDES; i++) begin : g_slot
        nexys_starship_monster_slot #(
            .TIMEOUT(TIMEOUT)
        ) u_slot (
            .clk_i        (Clk),
            .rst_ni       (Reset),
            .clear_i      (clear),
            .hold_i       (any_timeout),
            .tick_i       (play_tick),
            .spawn_grant_i(grant[i]),
            .shoot_i      (play_shoot[i]),
            .alive_o      (alive[i]),
            .age_o        (age[AGE_W*i +: AGE_W]),
            .timeout_o    (timeout[i]),
            .killed_o     (killed[i])
        );
    end

    // Survivors (alive and not shot) count against the cap;
    // empty slots then claim room in top > btm > left > right order.
    always_comb begin
        live  = popcount4(alive & ~killed);
        grant = '0;
        for (int i = 0; i < NUM_SIDES; i++) begin
            if (play_tick && !alive[i] && spawn_req[i] && live < CAP) begin
                grant[i] = 1'b1;
                live     = live + 3'd1;
            end
        end
    end

    always_comb begin
        n_kill    = popcount4(killed);
        score_sum = {1'b0, score_q} + {6'b0, n_kill};
        score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_GAMEOVER: begin
                    hit_q <= 1'b0;
                    if (start) begin
                        state_q     <= ST_PLAY;
                        score_q     <= '0;
                        game_over_q <= 1'b0;
                        playing_q   <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (any_timeout) begin
                        state_q     <= ST_GAMEOVER;
                        hit_q       <= 1'b0;
                        game_over_q <= 1'b1;
                        playing_q   <= 1'b0;
                    end else begin
                        score_q <= score_d;
                        hit_q   <= |killed;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hit_q       <= 1'b0;
                    game_over_q <= 1'b0;
                    playing_q   <= 1'b0;
                end
            endcase
        end
    end

    assign monster   = alive;
    assign score     = score_q;
    assign hit       = hit_q;
    assign game_over = game_over_q;
    assign playing   = playing_q;

endmodule

// File: tb/tb_nexys_starship_monster_ctrl.sv
// Scoreboard bench for nexys_starship_monster_ctrl: directed scenarios
// plus random play, checked against a behavioural game model.
module tb_nexys_starship_monster_ctrl;

    localparam int TMO  = 5;
    localparam int MAXA = 3;

    typedef struct packed {
        logic [3:0]  mon;
        logic [15:0] age;
        logic [7:0]  score;
        logic        hit;
        logic        go;
        logic        play;
    } obs_t;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic        tick;
    logic [3:0]  spawn_req;
    logic [3:0]  shoot;
    logic [3:0]  monster;
    logic [15:0] age;
    logic [7:0]  score;
    logic        hit;
    logic        game_over;
    logic        playing;

    nexys_starship_monster_ctrl #(
        .TIMEOUT   (TMO),
        .MAX_ACTIVE(MAXA)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (start),
        .tick     (tick),
        .spawn_req(spawn_req),
        .shoot    (shoot),
        .monster  (monster),
        .age      (age),
        .score    (score),
        .hit      (hit),
        .game_over(game_over),
        .playing  (playing)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];

    // model: 0 idle, 1 play, 2 game over
    int m_mode;
    bit m_alive[4];
    int m_age[4];
    int m_score;
    bit m_hit;

    function automatic obs_t snapshot();
        obs_t o;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            o.mon[i]         = m_alive[i];
            o.age[4*i +: 4]  = 4'(m_age[i]);
        end
        o.score = 8'(m_score);
        o.hit   = m_hit;
        o.go    = (m_mode == 2);
        o.play  = (m_mode == 1);
        return o;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_score = 0;
        m_hit   = 0;
        for (int i = 0; i < 4; i++) begin
            m_alive[i] = 0;
            m_age[i]   = 0;
        end
    endtask

    task automatic model(input bit st, input bit tk,
                         input logic [3:0] sp, input logic [3:0] sh);
        bit was[4];
        bit tmo;
        int kills;
        int live;
        if (m_mode != 1) begin
            m_hit = 0;
            if (st) begin
                model_reset();
                m_mode = 1;
            end
            return;
        end
        tmo = 0;
        for (int i = 0; i < 4; i++)
            if (m_alive[i] && tk && !sh[i] && m_age[i] == 1) tmo = 1;
        if (tmo) begin
            m_mode = 2;
            m_hit  = 0;
            return;
        end
        kills = 0;
        for (int i = 0; i < 4; i++) begin
            was[i] = m_alive[i];
            if (was[i] && sh[i]) begin
                m_alive[i] = 0;
                m_age[i]   = 0;
                kills++;
            end else if (was[i] && tk) begin
                m_age[i]--;
            end
        end
        live = 0;
        for (int i = 0; i < 4; i++) live += int'(m_alive[i]);
        for (int i = 0; i < 4; i++) begin
            if (tk && !was[i] && sp[i] && live < MAXA) begin
                m_alive[i] = 1;
                m_age[i]   = TMO;
                live++;
            end
        end
        m_score = (m_score + kills > 255) ? 255 : m_score + kills;
        m_hit   = (kills > 0);
    endtask

    task automatic step(input bit st, input bit tk,
                        input logic [3:0] sp, input logic [3:0] sh);
        @(negedge Clk);
        start     = st;
        tick      = tk;
        spawn_req = sp;
        shoot     = sh;
        model(st, tk, sp, sh);
        exp_q.push_back(snapshot());
    endtask

    task automatic check_obs(input string name, input obs_t e);
        obs_t a;
        a = {monster, age, score, hit, game_over, playing};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t: got mon=%b age=%h score=%0d hit=%b go=%b play=%b, want mon=%b age=%h score=%0d hit=%b go=%b play=%b",
                     name, $time, a.mon, a.age, a.score, a.hit, a.go, a.play,
                     e.mon, e.age, e.score, e.hit, e.go, e.play);
        end
    endtask

    // Monitor: outputs settle after each edge; compare the oldest expectation.
    initial begin
        obs_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_obs("cycle", e);
            end
        end
    end

    task automatic async_reset_check();
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        model_reset();
        #1;
        check_obs("async_reset", snapshot());
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        logic [3:0] mask;
        bit         st;
        bit         tk;
        logic [3:0] sh;
        Reset     = 1'b0;
        start     = 1'b0;
        tick      = 1'b0;
        spawn_req = '0;
        shoot     = '0;
        model_reset();
        #2;
        check_obs("reset_state", snapshot());
        @(negedge Clk);
        Reset = 1'b1;

        // first spawn, then time out after five ticks
        step(1, 0, 4'b0000, 4'b0000);
        step(0, 1, 4'b0001, 4'b0000);
        repeat (5) step(0, 1, 4'b0000, 4'b0000);
        step(0, 1, 4'b1111, 4'b1111);
        step(0, 0, 4'b0000, 4'b0000);

        // shot on the last tick saves the game
        step(1, 0, 4'b0000, 4'b0000);
        step(0, 1, 4'b0001, 4'b0000);
        repeat (4) step(0, 1, 4'b0000, 4'b0000);
        step(0, 1, 4'b0000, 4'b0001);
        step(0, 0, 4'b0000, 4'b0000);
        step(1, 0, 4'b0000, 4'b0000);

        // cap and shot-frees-a-place
        step(1, 0, 4'b0000, 4'b0000);
        step(0, 1, 4'b1111, 4'b0000);
        step(0, 1, 4'b1111, 4'b0001);
        step(0, 0, 4'b0000, 4'b0010);
        step(0, 0, 4'b0000, 4'b1111);

        // saturate the score
        step(1, 0, 4'b0000, 4'b0000);
        repeat (88) begin
            step(0, 1, 4'b1111, 4'b0000);
            step(0, 0, 4'b0000, 4'b1111);
        end
        step(0, 0, 4'b0000, 4'b0000);

        // mid-game reset with monster=0101, score=7
        step(1, 0, 4'b0000, 4'b0000);
        repeat (7) begin
            step(0, 1, 4'b0001, 4'b0000);
            step(0, 0, 4'b0000, 4'b0001);
        end
        step(0, 1, 4'b0101, 4'b0000);
        async_reset_check();
        repeat (4) step(0, 1, 4'b1111, 4'b0000);

        // random play
        repeat (3000) begin
            mask = '0;
            for (int i = 0; i < 4; i++) mask[i] = m_alive[i];
            st = ($urandom_range(0, 99) < 4);
            tk = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1)
                sh = 4'($urandom) & mask;
            else if ($urandom_range(0, 7) == 0)
                sh = 4'($urandom);
            else
                sh = 4'b0000;
            step(st, tk, 4'($urandom), sh);
            if ($urandom_range(0, 999) == 0) async_reset_check();
        end
        step(0, 0, 4'b0000, 4'b0000);

        repeat (3) @(posedge Clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
